// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg
//   Shared widths, tag/register null encodings, the retire classification
//   used by the ROB head, and the circular tag increment helper.
package reorder_buffer_pkg;

    localparam int unsigned ENTRY_SIZE = 4;
    localparam int unsigned ROB_SIZE   = 2 ** ENTRY_SIZE;
    localparam int unsigned REG_W      = 6;
    localparam int unsigned DATA_W     = 32;

    typedef logic [ENTRY_SIZE-1:0] entry_t;
    typedef logic [REG_W-1:0]      reg_t;
    typedef logic [DATA_W-1:0]     word_t;

    // Tag 0 is never allocated, so it can mean "no producer".
    localparam entry_t ENTRY_NULL = '0;
    localparam reg_t   REG_NULL   = '0;

    // What the head slot does on the current edge.
    typedef enum logic [1:0] {
        RET_IDLE,
        RET_COMMIT,
        RET_ROLLBACK
    } retire_e;

    // Circular increment that skips the reserved slot 0.
    function automatic entry_t entry_inc(input entry_t e);
        return (e == entry_t'(ROB_SIZE - 1)) ? entry_t'(1) : e + entry_t'(1);
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if
//   Issue, CDB, operand-query and commit signals of the reorder buffer.
//   master: the core side (decoder / CDB / reservation stations / regfile).
//   slave : the reorder buffer itself.
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    // issue
    logic   issue_valid;
    reg_t   issue_rd;
    logic   issue_is_branch;
    logic   issue_pred_taken;
    logic   issue_is_store;
    entry_t rob_new_entry;
    logic   rob_full;
    // common data bus
    logic   cdb_valid;
    entry_t cdb_entry;
    word_t  cdb_value;
    logic   cdb_taken;
    word_t  cdb_target;
    // operand lookup
    entry_t query_j_entry;
    entry_t query_k_entry;
    logic   query_j_ready;
    word_t  query_j_value;
    logic   query_k_ready;
    word_t  query_k_value;
    // commit / redirect
    logic   rob_commit;
    entry_t rob_entry;
    reg_t   rob_des;
    word_t  rob_result;
    logic   store_commit;
    logic   roll_back;
    word_t  roll_back_pc;

    modport master (
        output issue_valid, issue_rd, issue_is_branch, issue_pred_taken, issue_is_store,
        output cdb_valid, cdb_entry, cdb_value, cdb_taken, cdb_target,
        output query_j_entry, query_k_entry,
        input  rob_new_entry, rob_full,
        input  query_j_ready, query_j_value, query_k_ready, query_k_value,
        input  rob_commit, rob_entry, rob_des, rob_result,
        input  store_commit, roll_back, roll_back_pc
    );

    modport slave (
        input  issue_valid, issue_rd, issue_is_branch, issue_pred_taken, issue_is_store,
        input  cdb_valid, cdb_entry, cdb_value, cdb_taken, cdb_target,
        input  query_j_entry, query_k_entry,
        output rob_new_entry, rob_full,
        output query_j_ready, query_j_value, query_k_ready, query_k_value,
        output rob_commit, rob_entry, rob_des, rob_result,
        output store_commit, roll_back, roll_back_pc
    );

endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer
//   Circular in-order commit queue. Allocates a tag per issued instruction,
//   captures CDB results, forwards ready values to operand queries and
//   retires at most one instruction per cycle. A mispredicted branch at the
//   head flushes the whole buffer and raises roll_back.
// Ports
//   clk    : rising-edge clock
//   rst_in : asynchronous active-high reset
//   rdy_in : 0 freezes all state; registered outputs hold
//   rob    : reorder_buffer_if.slave (issue, CDB, query, commit)
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic            clk,
    input  logic            rst_in,
    input  logic            rdy_in,
    reorder_buffer_if.slave rob
);

    entry_t head, tail, count, count_next;
    logic [ROB_SIZE-1:0] busy, ready, is_br, pred, taken, is_st;
    reg_t  des    [ROB_SIZE];
    word_t value  [ROB_SIZE];
    word_t target [ROB_SIZE];

    retire_e retire;
    logic    full, issue_ok, cdb_ok;

    logic   commit_q, store_q, rb_q;
    entry_t entry_q;
    reg_t   des_q;
    word_t  result_q, rb_pc_q;

    assign full = (count == entry_t'(ROB_SIZE - 1));

    always_comb begin
        retire = RET_IDLE;
        if (busy[head] && ready[head])
            retire = (is_br[head] && (taken[head] != pred[head])) ? RET_ROLLBACK : RET_COMMIT;
        // Issues are dropped while roll_back is visible and on the flushing edge.
        issue_ok   = rob.issue_valid && !full && !rb_q && (retire != RET_ROLLBACK);
        cdb_ok     = rob.cdb_valid && (rob.cdb_entry != ENTRY_NULL) && busy[rob.cdb_entry];
        count_next = count + entry_t'(issue_ok) - entry_t'(retire == RET_COMMIT);
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            head     <= entry_t'(1);
            tail     <= entry_t'(1);
            count    <= '0;
            busy     <= '0;
            ready    <= '0;
            is_br    <= '0;
            pred     <= '0;
            taken    <= '0;
            is_st    <= '0;
            commit_q <= 1'b0;
            store_q  <= 1'b0;
            rb_q     <= 1'b0;
            rb_pc_q  <= '0;
            entry_q  <= '0;
            des_q    <= '0;
            result_q <= '0;
        end else if (rdy_in) begin
            commit_q <= 1'b0;
            store_q  <= 1'b0;
            rb_q     <= 1'b0;
            if (retire == RET_ROLLBACK) begin
                head    <= entry_t'(1);
                tail    <= entry_t'(1);
                count   <= '0;
                busy    <= '0;
                ready   <= '0;
                rb_q    <= 1'b1;
                rb_pc_q <= target[head];
            end else begin
                if (cdb_ok) begin
                    ready[rob.cdb_entry] <= 1'b1;
                    taken[rob.cdb_entry] <= rob.cdb_taken;
                end
                if (issue_ok) begin
                    busy[tail]  <= 1'b1;
                    ready[tail] <= 1'b0;
                    is_br[tail] <= rob.issue_is_branch;
                    pred[tail]  <= rob.issue_pred_taken;
                    is_st[tail] <= rob.issue_is_store;
                    tail        <= entry_inc(tail);
                end
                if (retire == RET_COMMIT) begin
                    busy[head]  <= 1'b0;
                    ready[head] <= 1'b0;
                    head        <= entry_inc(head);
                    commit_q    <= 1'b1;
                    store_q     <= is_st[head];
                    entry_q     <= head;
                    des_q       <= (is_br[head] || is_st[head]) ? REG_NULL : des[head];
                    result_q    <= value[head];
                end
                count <= count_next;
            end
        end
    end

    // Payload storage needs no reset: busy/ready gate every read that matters.
    always_ff @(posedge clk) begin
        if (rdy_in) begin
            if (cdb_ok) begin
                value[rob.cdb_entry]  <= rob.cdb_value;
                target[rob.cdb_entry] <= rob.cdb_target;
            end
            if (issue_ok)
                des[tail] <= rob.issue_rd;
        end
    end

    // Operand lookup: a same-cycle CDB hit wins over the stored value.
    always_comb begin
        rob.query_j_ready = 1'b0;
        rob.query_j_value = value[rob.query_j_entry];
        if (rob.query_j_entry != ENTRY_NULL) begin
            if (rob.cdb_valid && (rob.cdb_entry == rob.query_j_entry)) begin
                rob.query_j_ready = 1'b1;
                rob.query_j_value = rob.cdb_value;
            end else if (ready[rob.query_j_entry]) begin
                rob.query_j_ready = 1'b1;
            end
        end
    end

    always_comb begin
        rob.query_k_ready = 1'b0;
        rob.query_k_value = value[rob.query_k_entry];
        if (rob.query_k_entry != ENTRY_NULL) begin
            if (rob.cdb_valid && (rob.cdb_entry == rob.query_k_entry)) begin
                rob.query_k_ready = 1'b1;
                rob.query_k_value = rob.cdb_value;
            end else if (ready[rob.query_k_entry]) begin
                rob.query_k_ready = 1'b1;
            end
        end
    end

    assign rob.rob_new_entry = tail;
    assign rob.rob_full      = full;
    assign rob.rob_commit    = commit_q;
    assign rob.rob_entry     = entry_q;
    assign rob.rob_des       = des_q;
    assign rob.rob_result    = result_q;
    assign rob.store_commit  = store_q;
    assign rob.roll_back     = rb_q;
    assign rob.roll_back_pc  = rb_pc_q;

endmodule
